multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 52 +++++
 rtl/multicycle_control_if.sv | 30 +++
 rtl/multicycle_control_alu_decoder.sv | 29 ++
 rtl/multicycle_control.sv | 127 ++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// fields, ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_NONE leaves ALUControl at 000 in states that do not use the ALU.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction fields and Zero in, control strobes out.
interface multicycle_control_if #(parameter int STATE_W = 4);
  logic [5:0]         Op;
  logic [5:0]         Funct;
  logic               Zero;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUControl;
  logic [1:0]         PCSrc;
  logic               PCEn;
  logic [STATE_W-1:0] State;

  modport master (
    input  Op, Funct, Zero,
    output IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, State
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the FSM's ALUOp request plus the R-type Funct field onto the ALU operation code.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: every path assigns alu_control (defaults via case default), so no latch is inferred.
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  logic [STATE_W-1:0] state_q, state_d, cur_state;
  logic               iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
  logic               pcwrite, branch;
  logic [1:0]         alusrcb, pcsrc, alu_op;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for sequential state avoids read/write races between flops.
    if (reset) state_q <= STATE_W'(S_FETCH);
    else       state_q <= state_d;
  end

  // While reset is held, outputs decode as FETCH; write enables are masked below.
  assign cur_state = reset ? STATE_W'(S_FETCH) : state_q;

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PCSRC_ALU;
    alu_op   = ALUOP_NONE;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    state_d  = STATE_W'(S_FETCH);
    case (cur_state)
      STATE_W'(S_FETCH): begin
        irwrite = 1'b1;
        alusrcb = SRCB_FOUR;
        alu_op  = ALUOP_ADD;
        pcwrite = 1'b1;
        state_d = STATE_W'(S_DECODE);
      end
      STATE_W'(S_DECODE): begin
        alusrcb = SRCB_IMMSH;
        alu_op  = ALUOP_ADD;
        case (bus.Op)
          OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
          OP_RTYPE:     state_d = STATE_W'(S_RTYPEEX);
          OP_BEQ:       state_d = STATE_W'(S_BEQ);
          OP_ADDI:      state_d = STATE_W'(S_ADDIEX);
          OP_J:         state_d = STATE_W'(S_JUMP);
          default:      state_d = STATE_W'(S_FETCH);
        endcase
      end
      STATE_W'(S_MEMADR): begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        if (bus.Op == OP_LW)      state_d = STATE_W'(S_MEMRD);
        else if (bus.Op == OP_SW) state_d = STATE_W'(S_MEMWR);
      end
      STATE_W'(S_MEMRD): begin
        iord    = 1'b1;
        state_d = STATE_W'(S_MEMWB);
      end
      STATE_W'(S_MEMWB): begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      STATE_W'(S_MEMWR): begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      STATE_W'(S_RTYPEEX): begin
        alusrca = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = STATE_W'(S_ALUWB);
      end
      STATE_W'(S_ALUWB): begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      STATE_W'(S_BEQ): begin
        alusrca = 1'b1;
        alu_op  = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      STATE_W'(S_ADDIEX): begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = STATE_W'(S_ADDIWB);
      end
      STATE_W'(S_ADDIWB): regwrite = 1'b1;
      STATE_W'(S_JUMP): begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.Funct),
    .alu_control (bus.ALUControl)
  );

  assign bus.IorD     = iord;
  assign bus.MemWrite = memwrite & ~reset;
  assign bus.IRWrite  = irwrite & ~reset;
  assign bus.RegWrite = regwrite & ~reset;
  assign bus.RegDst   = regdst;
  assign bus.MemtoReg = memtoreg;
  assign bus.ALUSrcA  = alusrca;
  assign bus.ALUSrcB  = alusrcb;
  assign bus.PCSrc    = pcsrc;
  assign bus.PCEn     = (pcwrite | (branch & bus.Zero)) & ~reset;
  assign bus.State    = cur_state;

endmodule
